// File: rtl/ae_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ae_seq_pkg : shared state encoding and widths for the train FSM     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ae_seq_pkg;
  localparam int SAMPLE_W = 5;
  localparam int EPOCH_W  = 8;
  localparam int PHASE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FWD  = 3'd2,
    ST_BWD  = 3'd3,
    ST_UPD  = 3'd4,
    ST_DONE = 3'd5
  } seq_state_t;
endpackage
`default_nettype wire

// File: rtl/ae_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ae_phase_timer : loadable down-counter, flags the last phase cycle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ae_phase_timer
  import ae_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [PHASE_W-1:0] load_val,
  output logic               last
);
  localparam logic [PHASE_W-1:0] C_ONE = PHASE_W'(1);

  logic [PHASE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - C_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/ae_train_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ae_train_sequencer : FWD/BWD/UPD training-loop controller           |
// | Optional abort port: define AE_SEQ_ABORT_EN.        Rev 1.0         |
// +--------------------------------------------------------------------+
module ae_train_sequencer
  import ae_seq_pkg::*;
#(
  parameter int N_SAMPLE = 20,
  parameter int N_EPOCH  = 100,
  parameter int FWD_CYC  = 6,
  parameter int BWD_CYC  = 8,
  parameter int UPD_CYC  = 2
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AE_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                start,
  input  logic                hold,
  input  logic [SAMPLE_W-1:0] sample_q,
  output logic [SAMPLE_W-1:0] sample_d,
  output logic                fwd_en,
  output logic                bwd_en,
  output logic                upd_en,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                busy,
  output logic                done
);
  localparam logic [SAMPLE_W-1:0] C_LAST_IDX = SAMPLE_W'(N_SAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] C_IDX_ONE  = SAMPLE_W'(1);
  localparam logic [EPOCH_W-1:0]  C_EPOCHS   = EPOCH_W'(N_EPOCH);
  localparam logic [EPOCH_W-1:0]  C_EP_ONE   = EPOCH_W'(1);
  localparam logic [PHASE_W-1:0]  C_FWD_LD   = PHASE_W'(FWD_CYC - 1);
  localparam logic [PHASE_W-1:0]  C_BWD_LD   = PHASE_W'(BWD_CYC - 1);
  localparam logic [PHASE_W-1:0]  C_UPD_LD   = PHASE_W'(UPD_CYC - 1);

  seq_state_t         state_q, state_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_inc;
  logic               fwd_en_q, bwd_en_q, upd_en_q, busy_q, done_q;
  logic               fwd_en_d, bwd_en_d, upd_en_d, busy_d, done_d;
  logic               tmr_load, tmr_en, tmr_last;
  logic [PHASE_W-1:0] tmr_val;
  logic               abort_req;

`ifdef AE_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign epoch_inc = epoch_q + C_EP_ONE;

  always_comb begin
    state_d  = state_q;
    epoch_d  = epoch_q;
    sample_d = sample_q;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sample_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          epoch_d = '0;
        end
      end
      ST_LOAD: begin
        sample_d = '0;
        if (!hold) state_d = ST_FWD;
      end
      ST_FWD: if (!hold) begin
        if (tmr_last) state_d = ST_BWD;
        else          tmr_en  = 1'b1;
      end
      ST_BWD: if (!hold) begin
        if (tmr_last) state_d = ST_UPD;
        else          tmr_en  = 1'b1;
      end
      ST_UPD: if (!hold) begin
        if (!tmr_last) begin
          tmr_en = 1'b1;
        end else if (sample_q == C_LAST_IDX) begin
          sample_d = '0;
          epoch_d  = epoch_inc;
          state_d  = (epoch_inc == C_EPOCHS) ? ST_DONE : ST_FWD;
        end else begin
          sample_d = sample_q + C_IDX_ONE;
          state_d  = ST_FWD;
        end
      end
      // DONE always retires to IDLE so done stays a single-cycle pulse.
      ST_DONE: begin
        sample_d = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        sample_d = '0;
        state_d  = ST_IDLE;
      end
    endcase

    if (abort_req && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      epoch_d  = epoch_q;
      sample_d = '0;
      tmr_en   = 1'b0;
    end

    // Any state change reloads the timer; non-phase targets park it at zero.
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_FWD:  tmr_val = C_FWD_LD;
      ST_BWD:  tmr_val = C_BWD_LD;
      ST_UPD:  tmr_val = C_UPD_LD;
      default: tmr_val = '0;
    endcase

    fwd_en_d = (state_d == ST_FWD);
    bwd_en_d = (state_d == ST_BWD);
    upd_en_d = (state_d == ST_UPD);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      epoch_q  <= '0;
      fwd_en_q <= 1'b0;
      bwd_en_q <= 1'b0;
      upd_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      epoch_q  <= epoch_d;
      fwd_en_q <= fwd_en_d;
      bwd_en_q <= bwd_en_d;
      upd_en_q <= upd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  ae_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  assign fwd_en = fwd_en_q;
  assign bwd_en = bwd_en_q;
  assign upd_en = upd_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign epoch  = epoch_q;
endmodule
`default_nettype wire

// File: tb/tb_ae_train_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ae_train_sequencer : directed bench, N_SAMPLE=3 N_EPOCH=2 2/3/1  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ae_train_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [4:0] sample_q, sample_d, mem_q;
  logic       fwd_en, bwd_en, upd_en, busy, done;
  logic [7:0] epoch;
`ifdef AE_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // counter_mem stand-in: plain register, deliberately without reset
  always_ff @(posedge clk) mem_q <= sample_d;
  assign sample_q = mem_q;

  ae_train_sequencer #(
    .N_SAMPLE(3), .N_EPOCH(2), .FWD_CYC(2), .BWD_CYC(3), .UPD_CYC(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AE_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .hold     (hold),
    .sample_q (sample_q),
    .sample_d (sample_d),
    .fwd_en   (fwd_en),
    .bwd_en   (bwd_en),
    .upd_en   (upd_en),
    .epoch    (epoch),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_run;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done (bounded); pulses start at cycles p1/p2 to prove it is ignored.
  task automatic run_track(input int p1, input int p2, output int cyc, output int nf,
                           output int nb, output int nu, output logic [29:0] seq,
                           output logic xbad);
    logic prevf;
    cyc = 0; nf = 0; nb = 0; nu = 0; seq = '0; xbad = 1'b0; prevf = 1'b0;
    while (done !== 1'b1 && cyc < 300) begin
      start = (cyc == p1) || (cyc == p2);
      tick();
      cyc++;
      if (fwd_en === 1'b1) nf++;
      if (bwd_en === 1'b1) nb++;
      if (upd_en === 1'b1) nu++;
      if (fwd_en === 1'b1 && !prevf) seq = {seq[24:0], sample_q};
      prevf = (fwd_en === 1'b1);
      if ($isunknown(sample_d)) xbad = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, nf, nb, nu, c0, k, r;
    logic [29:0] seq;
    logic [29:0] exp_seq;
    logic xbad, hold_ok;
    exp_seq = {5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2};

    rst = 1'b1; start = 1'b0; hold = 1'b0;
    tick(); tick();
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_fwd",    32'(fwd_en),   32'd0);
    chk("rst_done",   32'(done),     32'd0);
    chk("rst_epoch",  32'(epoch),    32'd0);
    chk("rst_sdata",  32'(sample_d), 32'd0);
    rst = 1'b0;

    // Run 1: unperturbed, start in first cycle after reset
    begin_run();
    chk("load_busy", 32'(busy),   32'd1);
    chk("load_fwd",  32'(fwd_en), 32'd0);
    run_track(-1, -1, cyc, nf, nb, nu, seq, xbad);
    chk("r1_latency", 32'(cyc),  32'd37);
    chk("r1_fwd_cyc", 32'(nf),   32'd12);
    chk("r1_bwd_cyc", 32'(nb),   32'd18);
    chk("r1_upd_cyc", 32'(nu),   32'd6);
    chk("r1_seq",     32'(seq),  32'(exp_seq));
    chk("r1_noX",     32'(xbad), 32'd0);
    chk("r1_epoch",   32'(epoch), 32'd2);
    tick();
    chk("r1_done_pulse", 32'(done), 32'd0);
    chk("r1_idle_busy",  32'(busy), 32'd0);
    chk("r1_epoch_hold", 32'(epoch), 32'd2);

    // Run 2: start pulsed while busy
    begin_run();
    run_track(5, 20, cyc, nf, nb, nu, seq, xbad);
    chk("r2_latency", 32'(cyc), 32'd37);
    chk("r2_seq",     32'(seq), 32'(exp_seq));
    tick();
    chk("r2_idle_busy", 32'(busy), 32'd0);

    // Run 3: hold for 5 cycles in the first BWD of sample 0
    begin_run();
    c0 = 0;
    do begin tick(); c0++; end while (bwd_en !== 1'b1 && c0 < 50);
    chk("r3_bwd_start", 32'(c0), 32'd3);
    hold = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bwd_en !== 1'b1 || sample_q !== 5'd0 || epoch !== 8'd0) hold_ok = 1'b0;
    end
    hold = 1'b0;
    chk("r3_hold_frozen", 32'(hold_ok), 32'd1);
    k = 0;
    do begin tick(); k++; end while (bwd_en === 1'b1 && k < 50);
    chk("r3_bwd_len", 32'(1 + 5 + k - 1), 32'd8);
    run_track(-1, -1, r, nf, nb, nu, seq, xbad);
    chk("r3_latency", 32'(c0 + 5 + k + r), 32'd42);
    tick();

    // Run 4: reset pulsed during UPD of epoch 1
    begin_run();
    c0 = 0;
    while (!(upd_en === 1'b1 && epoch === 8'd1) && c0 < 300) begin tick(); c0++; end
    chk("r4_found_upd", 32'(c0 < 300), 32'd1);
    rst = 1'b1;
    #1;
    chk("r4_busy",  32'(busy),     32'd0);
    chk("r4_epoch", 32'(epoch),    32'd0);
    chk("r4_upd",   32'(upd_en),   32'd0);
    chk("r4_sdata", 32'(sample_d), 32'd0);
    tick();
    rst = 1'b0;
    begin_run();
    tick();
    chk("r4_restart_fwd", 32'(fwd_en),   32'd1);
    chk("r4_restart_idx", 32'(sample_q), 32'd0);
    run_track(-1, -1, cyc, nf, nb, nu, seq, xbad);
    chk("r4_latency", 32'(cyc + 1), 32'd37);
    tick();

`ifdef AE_SEQ_ABORT_EN
    // Run 5: abort during FWD of sample 2
    begin_run();
    c0 = 0;
    while (!(fwd_en === 1'b1 && sample_q === 5'd2) && c0 < 300) begin tick(); c0++; end
    chk("r5_found_fwd2", 32'(c0 < 300), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("r5_busy",  32'(busy),     32'd0);
    chk("r5_done",  32'(done),     32'd0);
    chk("r5_sdata", 32'(sample_d), 32'd0);
    chk("r5_epoch", 32'(epoch),    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
